// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller for the single-cycle core.
// Turns the harness req/done handshake into start/run/stop sequencing:
// selects a program entry point, pulses the PC load and shift/carry clear,
// gates core execution, detects halt, reports completion and counts RUN cycles.
//
// Optional feature macro: PROG_SEQ_WATCHDOG_EN (RUN-cycle watchdog, err on expiry).
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_req        start request from harness (level)
//   i_prog_sel   program index, sampled on acceptance; 3 is invalid
//   i_halt       decoded halt instruction, meaningful only in RUN
//   o_core_en    enables PC advance / RegWrite / MemWrite in the core
//   o_pc_init    one-cycle pulse: PC loads o_init_addr
//   o_init_addr  entry address of the selected program
//   o_sc_clr     one-cycle pulse clearing the shift/carry register
//   o_done       program finished; held until i_req drops
//   o_err        invalid program index or watchdog expiry; valid with o_done
//   o_cycles     RUN-cycle count of current/last program (saturating)
module prog_sequencer #(
  parameter int unsigned          pc_width  = 12,
  parameter int unsigned          cyc_width = 16,
  parameter logic [pc_width-1:0]  START0    = pc_width'(0),
  parameter logic [pc_width-1:0]  START1    = pc_width'(256),
  parameter logic [pc_width-1:0]  START2    = pc_width'(512),
  parameter int unsigned          TIMEOUT   = 4095
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic [1:0]           i_prog_sel,
  input  logic                 i_halt,
  output logic                 o_core_en,
  output logic                 o_pc_init,
  output logic [pc_width-1:0]  o_init_addr,
  output logic                 o_sc_clr,
  output logic                 o_done,
  output logic                 o_err,
  output logic [cyc_width-1:0] o_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_core_en;
  logic                  r_pc_init;
  logic [pc_width-1:0]   r_init_addr;
  logic                  r_sc_clr;
  logic                  r_done;
  logic                  r_err;
  logic [cyc_width-1:0]  r_cycles;

  logic [cyc_width-1:0]  w_cyc_inc;
  logic [pc_width-1:0]   w_entry;
  logic                  w_timeout;

  // Saturating increment of the RUN-cycle counter
  assign w_cyc_inc = (r_cycles == {cyc_width{1'b1}}) ? r_cycles
                                                     : r_cycles + cyc_width'(1);

  // Entry address lookup; index 3 never reaches INIT
  always_comb begin
    w_entry = START0;
    case (i_prog_sel)
      2'd1:    w_entry = START1;
      2'd2:    w_entry = START2;
      default: w_entry = START0;
    endcase
  end

`ifdef PROG_SEQ_WATCHDOG_EN
  // Expiry when the current RUN cycle is the TIMEOUT-th one
  assign w_timeout = (32'(w_cyc_inc) == 32'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^32'(TIMEOUT);
`endif

  // Sequencer FSM with registered (Moore) outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_core_en   <= 1'b0;
      r_pc_init   <= 1'b0;
      r_init_addr <= '0;
      r_sc_clr    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cycles    <= '0;
    end else begin
      r_pc_init <= 1'b0;
      r_sc_clr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            if (i_prog_sel != 2'd3) begin
              r_state     <= S_INIT;
              r_init_addr <= w_entry;
              r_pc_init   <= 1'b1;
              r_sc_clr    <= 1'b1;
              r_cycles    <= '0;
              r_err       <= 1'b0;
            end else begin
              // Invalid program: report failure without touching the core
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_cycles <= '0;
            end
          end
        end
        S_INIT: begin
          r_state   <= S_RUN;
          r_core_en <= 1'b1;
        end
        S_RUN: begin
          // The halt cycle is an executed cycle, so it is counted
          r_cycles <= w_cyc_inc;
          if (i_halt) begin
            r_state   <= S_DRAIN;
            r_core_en <= 1'b0;
          end else if (w_timeout) begin
            r_state   <= S_DRAIN;
            r_core_en <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          if (!i_req) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_core_en <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_core_en   = r_core_en;
  assign o_pc_init   = r_pc_init;
  assign o_init_addr = r_init_addr;
  assign o_sc_clr    = r_sc_clr;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cycles    = r_cycles;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer. Main instance uses default widths with
// TIMEOUT=20; a second instance with a 4-bit cycle counter covers saturation.
module tb_prog_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  sel;
  logic        halt;
  logic        core_en, pc_init, sc_clr, done, err;
  logic [11:0] init_addr;
  logic [15:0] cycles;

  logic        s_req;
  logic [1:0]  s_sel;
  logic        s_halt;
  logic        s_core_en, s_pc_init, s_sc_clr, s_done, s_err;
  logic [11:0] s_init_addr;
  logic [3:0]  s_cycles;

  int checks;
  int failures;

  prog_sequencer #(.TIMEOUT(20)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_prog_sel(sel), .i_halt(halt),
    .o_core_en(core_en), .o_pc_init(pc_init), .o_init_addr(init_addr),
    .o_sc_clr(sc_clr), .o_done(done), .o_err(err), .o_cycles(cycles)
  );

  prog_sequencer #(.cyc_width(4)) dut_small (
    .i_clk(clk), .i_reset(rst_n), .i_req(s_req), .i_prog_sel(s_sel), .i_halt(s_halt),
    .o_core_en(s_core_en), .o_pc_init(s_pc_init), .o_init_addr(s_init_addr),
    .o_sc_clr(s_sc_clr), .o_done(s_done), .o_err(s_err), .o_cycles(s_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; sel = 2'd0; halt = 1'b0;
    s_req = 1'b0; s_sel = 2'd0; s_halt = 1'b0;
    #12;
    checks++; if ({core_en, pc_init, sc_clr, done, err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {core_en, pc_init, sc_clr, done, err}); end
    checks++; if (init_addr !== 12'd0) begin failures++; $display("FAIL reset_init_addr got=%0d exp=0", init_addr); end
    checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    tick(); rst_n = 1'b1; tick();
    checks++; if ({core_en, pc_init, done} !== 3'b0) begin failures++; $display("FAIL reset_idle got=%b exp=000", {core_en, pc_init, done}); end
  endtask

  task automatic test_invalid();
    req = 1'b1; sel = 2'd3; tick();
    checks++; if ({done, err} !== 2'b11) begin failures++; $display("FAIL inv_done_err got=%b exp=11", {done, err}); end
    checks++; if ({pc_init, sc_clr, core_en} !== 3'b0) begin failures++; $display("FAIL inv_no_start got=%b exp=000", {pc_init, sc_clr, core_en}); end
    checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL inv_cycles got=%0d exp=0", cycles); end
    tick();
    checks++; if ({done, err, pc_init, core_en} !== 4'b1100) begin failures++; $display("FAIL inv_hold got=%b exp=1100", {done, err, pc_init, core_en}); end
    req = 1'b0; tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL inv_release got=%b exp=0", done); end
  endtask

  task automatic test_basic();
    req = 1'b1; sel = 2'd1; tick();
    checks++; if ({pc_init, sc_clr, core_en} !== 3'b110) begin failures++; $display("FAIL basic_init got=%b exp=110", {pc_init, sc_clr, core_en}); end
    checks++; if (init_addr !== 12'd256) begin failures++; $display("FAIL basic_addr got=%0d exp=256", init_addr); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err_clr got=%b exp=0", err); end
    sel = 2'd2; tick();
    checks++; if ({pc_init, sc_clr, core_en} !== 3'b001) begin failures++; $display("FAIL basic_run got=%b exp=001", {pc_init, sc_clr, core_en}); end
    repeat (9) tick();
    checks++; if (cycles !== 16'd9 || core_en !== 1'b1) begin failures++; $display("FAIL basic_run10 cycles=%0d en=%b exp=9,1", cycles, core_en); end
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if ({core_en, done} !== 2'b00 || cycles !== 16'd10) begin failures++; $display("FAIL basic_drain en_done=%b cycles=%0d exp=00,10", {core_en, done}, cycles); end
    tick();
    checks++; if ({done, err} !== 2'b10 || cycles !== 16'd10) begin failures++; $display("FAIL basic_done done_err=%b cycles=%0d exp=10,10", {done, err}, cycles); end
    checks++; if (init_addr !== 12'd256) begin failures++; $display("FAIL basic_addr_hold got=%0d exp=256", init_addr); end
    repeat (3) tick();
    checks++; if ({done, pc_init, core_en} !== 3'b100) begin failures++; $display("FAIL basic_done_hold got=%b exp=100", {done, pc_init, core_en}); end
    req = 1'b0; tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", done); end
  endtask

  task automatic test_ignore();
    req = 1'b1; sel = 2'd0; tick();
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if ({core_en, done} !== 2'b10) begin failures++; $display("FAIL ign_init_halt got=%b exp=10", {core_en, done}); end
    req = 1'b0; repeat (3) tick();
    checks++; if ({core_en, done} !== 2'b10 || cycles !== 16'd3) begin failures++; $display("FAIL ign_req_drop en_done=%b cycles=%0d exp=10,3", {core_en, done}, cycles); end
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if (cycles !== 16'd4 || core_en !== 1'b0) begin failures++; $display("FAIL ign_drain cycles=%0d en=%b exp=4,0", cycles, core_en); end
    req = 1'b1; tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if ({done, core_en, pc_init, err} !== 4'b1000 || cycles !== 16'd4) begin failures++; $display("FAIL ign_done_halt flags=%b cycles=%0d exp=1000,4", {done, core_en, pc_init, err}, cycles); end
    req = 1'b0; tick();
    halt = 1'b1; tick(); halt = 1'b0;
    checks++; if ({done, core_en, pc_init} !== 3'b000) begin failures++; $display("FAIL ign_idle_halt got=%b exp=000", {done, core_en, pc_init}); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; sel = 2'd0; tick(); tick();
    halt = 1'b1; tick(); halt = 1'b0;
    tick(); repeat (3) tick();
    checks++; if ({done, pc_init, core_en} !== 3'b100) begin failures++; $display("FAIL b2b_no_restart got=%b exp=100", {done, pc_init, core_en}); end
    req = 1'b0; tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", done); end
    req = 1'b1; sel = 2'd2; tick();
    checks++; if (pc_init !== 1'b1 || init_addr !== 12'd512 || cycles !== 16'd0) begin failures++; $display("FAIL b2b_init pc_init=%b addr=%0d cycles=%0d exp=1,512,0", pc_init, init_addr, cycles); end
    sel = 2'd0; tick(); tick();
    halt = 1'b1; tick(); halt = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || cycles !== 16'd2 || init_addr !== 12'd512) begin failures++; $display("FAIL b2b_done done=%b cycles=%0d addr=%0d exp=1,2,512", done, cycles, init_addr); end
    req = 1'b0; tick();
  endtask

  task automatic test_reset_mid_run();
    req = 1'b1; sel = 2'd2; tick(); tick(); tick();
    req = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({core_en, pc_init, sc_clr, done, err} !== 5'b0 || init_addr !== 12'd0 || cycles !== 16'd0) begin failures++; $display("FAIL rst_mid flags=%b addr=%0d cycles=%0d exp=00000,0,0", {core_en, pc_init, sc_clr, done, err}, init_addr, cycles); end
    #1 rst_n = 1'b1;
    tick(); tick();
    checks++; if ({core_en, pc_init, done} !== 3'b000) begin failures++; $display("FAIL rst_mid_idle got=%b exp=000", {core_en, pc_init, done}); end
    req = 1'b1; sel = 2'd1; tick();
    checks++; if (pc_init !== 1'b1 || init_addr !== 12'd256) begin failures++; $display("FAIL rst_mid_restart pc_init=%b addr=%0d exp=1,256", pc_init, init_addr); end
    tick(); halt = 1'b1; tick(); halt = 1'b0; tick();
    checks++; if (done !== 1'b1 || cycles !== 16'd1) begin failures++; $display("FAIL rst_mid_done done=%b cycles=%0d exp=1,1", done, cycles); end
    req = 1'b0; tick();
  endtask

  task automatic test_saturate();
    s_req = 1'b1; s_sel = 2'd1; tick(); tick();
    repeat (19) tick();
    checks++; if (s_cycles !== 4'd15 || s_done !== 1'b0 || s_core_en !== 1'b1) begin failures++; $display("FAIL sat_run cycles=%0d done=%b en=%b exp=15,0,1", s_cycles, s_done, s_core_en); end
    s_halt = 1'b1; tick(); s_halt = 1'b0; tick();
    checks++; if (s_cycles !== 4'd15 || {s_done, s_err} !== 2'b10) begin failures++; $display("FAIL sat_done cycles=%0d done_err=%b exp=15,10", s_cycles, {s_done, s_err}); end
    s_req = 1'b0; tick();
  endtask

`ifdef PROG_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    req = 1'b1; sel = 2'd0; tick(); tick();
    repeat (19) tick();
    checks++; if (core_en !== 1'b1 || cycles !== 16'd19) begin failures++; $display("FAIL wd_run20 en=%b cycles=%0d exp=1,19", core_en, cycles); end
    tick();
    checks++; if (core_en !== 1'b0 || err !== 1'b1 || cycles !== 16'd20) begin failures++; $display("FAIL wd_drain en=%b err=%b cycles=%0d exp=0,1,20", core_en, err, cycles); end
    tick();
    checks++; if ({done, err} !== 2'b11) begin failures++; $display("FAIL wd_done got=%b exp=11", {done, err}); end
    req = 1'b0; tick();
    req = 1'b1; tick(); tick();
    repeat (19) tick();
    halt = 1'b1; tick(); halt = 1'b0; tick();
    checks++; if ({done, err} !== 2'b10 || cycles !== 16'd20) begin failures++; $display("FAIL wd_halt_wins done_err=%b cycles=%0d exp=10,20", {done, err}, cycles); end
    req = 1'b0; tick();
  endtask
`else
  task automatic test_no_timeout();
    req = 1'b1; sel = 2'd0; tick(); tick();
    repeat (25) tick();
    checks++; if (core_en !== 1'b1 || done !== 1'b0 || cycles !== 16'd25) begin failures++; $display("FAIL nowd_run en=%b done=%b cycles=%0d exp=1,0,25", core_en, done, cycles); end
    halt = 1'b1; tick(); halt = 1'b0; tick();
    checks++; if ({done, err} !== 2'b10 || cycles !== 16'd26) begin failures++; $display("FAIL nowd_done done_err=%b cycles=%0d exp=10,26", {done, err}, cycles); end
    req = 1'b0; tick();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_invalid();
    test_basic();
    test_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_saturate();
`ifdef PROG_SEQ_WATCHDOG_EN
    test_watchdog();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller for the single-cycle core: turns the external req/done handshake into per-program start, run and stop sequencing.
- Selects one of three program entry points, loads the PC, clears the shift/carry flag, gates core execution, detects the halt instruction and reports completion.
- Counts execution cycles.
- Sits between the test harness and the fetch/control subassembly; replaces the hard-coded prog_ctr==128 completion compare.

Parameters:
- pc_width, 12, width of program counter and entry addresses
- cyc_width, 16, width of cycle counter
- START0, 12'd0, entry address of program 0
- START1, 12'd256, entry address of program 1
- START2, 12'd512, entry address of program 2
- TIMEOUT, 16'd4095, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- req  input  1  start request from harness, level
- prog_sel  input  2  program index, sampled when req is accepted; 3 is invalid
- halt  input  1  decoded halt instruction from control decoder, valid while core_en=1
- core_en  output  1  enables PC advance, RegWrite and MemWrite in the core
- pc_init  output  1  one-cycle pulse: PC loads init_addr
- init_addr  output  pc_width  entry address for the selected program
- sc_clr  output  1  one-cycle pulse clearing the shift/carry register, coincident with pc_init
- done  output  1  program finished; held until req drops
- err  output  1  invalid prog_sel or watchdog expiry; valid while done=1
- cycles  output  cyc_width  RUN-cycle count of current/last program

Behaviour:
- All outputs registered (Moore). Reset (reset=0, asynchronous) forces state IDLE and all outputs to 0, including cycles and init_addr; applies mid-run.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE:
  - req=1 and prog_sel<3 at edge k -> INIT. prog_sel is latched; init_addr = START[prog_sel] from edge k.
  - req=1 and prog_sel==3 -> DONE with err=1. No INIT, no core_en.
  - req=0 -> stay in IDLE.
- INIT (exactly 1 cycle):
  - pc_init=1, sc_clr=1, core_en=0; cycles cleared to 0; err cleared.
  - Next state RUN.
- RUN:
  - core_en=1 beginning cycle k+2 after acceptance at edge k.
  - cycles increments by 1 on every RUN cycle, saturating at all-ones (no wrap).
  - halt=1 -> DRAIN. The halt cycle itself is counted; halt is the last executed instruction.
  - req deasserting in RUN is ignored; the program runs to completion.
- DRAIN (exactly 1 cycle): core_en=0, lets the final register/memory write settle. Next state DONE.
- DONE:
  - done=1, core_en=0; cycles and err are held.
  - Stay while req=1. req=0 -> IDLE with done=0 next cycle.
  - A new program requires req low for at least one cycle, then high again.
- halt is ignored outside RUN.
- prog_sel changes after acceptance have no effect.
- init_addr holds its last value outside INIT.

Optional Feature:
- Macro: PROG_SEQ_WATCHDOG_EN.
- Defined:
  - In RUN, if cycles == TIMEOUT and halt=0 on that cycle -> DRAIN, then DONE with err=1.
  - halt and timeout on the same cycle: halt wins, err=0.
- Undefined:
  - No timeout; RUN continues until halt; cycles saturates.
  - err is set only by an invalid prog_sel. TIMEOUT is unused.

Test Plan:
- Reset during RUN (reset=0 at arbitrary phase) -> same cycle all outputs 0; after release, state IDLE; req=1 needed to restart.
- req=1, prog_sel=1 at edge 0 -> pc_init=sc_clr=1 and init_addr=256 during cycle 1; core_en=1 from cycle 2; halt at 10th RUN cycle -> cycles=10, DRAIN one cycle, done=1, err=0; done held until req=0, then done=0 next cycle.
- req=1, prog_sel=3 -> done=1, err=1 next cycle; pc_init and core_en never asserted; cycles stays 0.
- Back-to-back runs: req held high after done -> no restart; req low 1 cycle, then high with prog_sel=2 -> init_addr=512, cycles restarts from 0.
- halt pulsed during INIT and DONE -> ignored; req dropped mid-RUN -> run continues to halt.
- PROG_SEQ_WATCHDOG_EN with TIMEOUT=20, no halt -> err=1, done=1, cycles=20. Same with halt on cycle 20 -> err=0. Without the macro and cyc_width=4, no halt -> cycles saturates at 15, done stays 0.
